// File: rtl/stereo_matrix_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : stereo_matrix_decoder_if
//  Description : Sample-side bundle for the stereo matrix decoder.
//                Carries the 48 kHz strobe, the sum/difference input pair,
//                the gain, the reconstructed LEFT/RIGHT pair and the status
//                flags (valid, busy, overrun).
//                  master : the block that supplies samples and reads results
//                  slave  : the decoder itself
//  Revision    : 1.0  initial release
// ============================================================================
interface stereo_matrix_decoder_if;

    logic               clken_48;   // one-cycle 48 kHz sample strobe
    logic signed [17:0] LpR;        // sum channel sample (L+R)
    logic signed [17:0] LmR;        // difference channel sample (L-R)
    logic        [3:0]  Kg;         // output gain, 8 = unity
    logic signed [17:0] LEFT;       // reconstructed left sample
    logic signed [17:0] RIGHT;      // reconstructed right sample
    logic               valid;      // one-cycle pulse when LEFT/RIGHT update
    logic               busy;       // a sample is in flight
    logic               overrun;    // sticky: strobe arrived while busy

    modport master (
        output clken_48, LpR, LmR, Kg,
        input  LEFT, RIGHT, valid, busy, overrun
    );

    modport slave (
        input  clken_48, LpR, LmR, Kg,
        output LEFT, RIGHT, valid, busy, overrun
    );

endinterface

`default_nettype wire

// File: rtl/stereo_matrix_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : stereo_matrix_decoder
//  Description : Stereo matrix decoder. On each 48 kHz strobe it captures a
//                sum (L+R) and difference (L-R) pair and reconstructs
//                LEFT = (LpR+LmR)*Kg/8 and RIGHT = (LpR-LmR)*Kg/8 using one
//                shared 4-cycle shift-add multiplier (left then right).
//                Result appears 9 cycles after the capture edge.
//
//  Ports       : clock          system clock
//                reset          synchronous, active-high reset
//                bus (slave)    clken_48, LpR, LmR, Kg      -> inputs
//                               LEFT, RIGHT, valid, busy,
//                               overrun                     <- outputs
//
//  Build macro : STEREO_DEC_SAT_EN
//                  defined   -> 21-bit results saturate to 18-bit range
//                  undefined -> 21-bit results wrap to their low 18 bits
//  Revision    : 1.0  initial release
// ============================================================================
module stereo_matrix_decoder (
    input  wire logic              clock,
    input  wire logic              reset,
    stereo_matrix_decoder_if.slave bus
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_MUL_L = 2'd1;
    localparam logic [1:0] c_MUL_R = 2'd2;
    localparam logic [1:0] c_OUT   = 2'd3;

    // Width of the stored per-channel result. With saturation the full
    // 21-bit scaled value is needed to detect overflow; with plain wrap only
    // the low 18 bits ever reach the outputs, so only those are kept.
`ifdef STEREO_DEC_SAT_EN
    localparam int c_RES_W = 21;
`else
    localparam int c_RES_W = 18;
`endif

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [1:0]                r_state;
    logic [1:0]                w_next_state;

    logic                      w_busy;
    logic                      w_capture;
    logic                      w_mul;
    logic                      w_load_out;

    logic signed [18:0]        r_sum;
    logic signed [18:0]        r_diff;
    logic        [3:0]         r_gain;
    logic        [1:0]         r_bit_cnt;
    logic signed [23:0]        r_acc;
    logic signed [c_RES_W-1:0] r_res_l;
    logic signed [c_RES_W-1:0] r_res_r;

    logic signed [17:0]        r_left;
    logic signed [17:0]        r_right;
    logic                      r_valid;
    logic                      r_overrun;

    logic signed [18:0]        w_sum;
    logic signed [18:0]        w_diff;
    logic signed [18:0]        w_operand;
    logic signed [23:0]        w_addend;
    logic signed [23:0]        w_acc_next;
    logic                      w_last_bit;
    logic signed [c_RES_W-1:0] w_scaled;

    // ------------------------------------------------------------------
    // Narrowing of a stored result onto the 18-bit output range
    // ------------------------------------------------------------------
`ifdef STEREO_DEC_SAT_EN
    function automatic logic signed [17:0] f_narrow(input logic signed [20:0] v);
        logic signed [17:0] r;
        if (v > 21'sd131071) begin
            r = 18'sh1FFFF;
        end else if (v < -21'sd131072) begin
            r = 18'sh20000;
        end else begin
            r = v[17:0];
        end
        return r;
    endfunction
`else
    // Only the low 18 bits were kept, so wrap is already done.
    function automatic logic signed [17:0] f_narrow(input logic signed [17:0] v);
        return v;
    endfunction
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (bus.clken_48) begin
                    w_next_state = c_MUL_L;
                end
            end
            c_MUL_L: begin
                if (w_last_bit) begin
                    w_next_state = c_MUL_R;
                end
            end
            c_MUL_R: begin
                if (w_last_bit) begin
                    w_next_state = c_OUT;
                end
            end
            c_OUT: begin
                w_next_state = c_IDLE;
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_busy     = 1'b0;
        w_capture  = 1'b0;
        w_mul      = 1'b0;
        w_load_out = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_capture = bus.clken_48;
            end
            c_MUL_L, c_MUL_R: begin
                w_busy = 1'b1;
                w_mul  = 1'b1;
            end
            c_OUT: begin
                w_busy     = 1'b1;
                w_load_out = 1'b1;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath combinational
    // ------------------------------------------------------------------
    // 19-bit sum/difference of two 18-bit signed values is always exact.
    assign w_sum  = {bus.LpR[17], bus.LpR} + {bus.LmR[17], bus.LmR};
    assign w_diff = {bus.LpR[17], bus.LpR} - {bus.LmR[17], bus.LmR};

    // MUL_L multiplies the sum, MUL_R the difference.
    assign w_operand  = (r_state == c_MUL_R) ? r_diff : r_sum;
    assign w_addend   = {{5{w_operand[18]}}, w_operand} << r_bit_cnt;
    assign w_acc_next = r_acc + (r_gain[r_bit_cnt] ? w_addend : 24'sd0);
    assign w_last_bit = (r_bit_cnt == 2'd3);

    // Dropping the low three bits of the two's-complement accumulator is an
    // arithmetic shift right by 3, i.e. division by 8 rounded toward -inf.
    assign w_scaled   = w_acc_next[c_RES_W+2:3];

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sum     <= '0;
            r_diff    <= '0;
            r_gain    <= '0;
            r_bit_cnt <= '0;
            r_acc     <= '0;
            r_res_l   <= '0;
            r_res_r   <= '0;
            r_left    <= '0;
            r_right   <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_valid <= 1'b0;

            // A strobe during any non-idle state (OUT included) is dropped
            // and remembered until reset.
            if (bus.clken_48 && w_busy) begin
                r_overrun <= 1'b1;
            end

            if (w_capture) begin
                r_sum     <= w_sum;
                r_diff    <= w_diff;
                r_gain    <= bus.Kg;
                r_acc     <= '0;
                r_bit_cnt <= '0;
            end

            if (w_mul) begin
                // Counter wraps 3 -> 0, ready for the next channel.
                r_bit_cnt <= r_bit_cnt + 2'd1;
                if (w_last_bit) begin
                    r_acc <= '0;
                    if (r_state == c_MUL_L) begin
                        r_res_l <= w_scaled;
                    end else begin
                        r_res_r <= w_scaled;
                    end
                end else begin
                    r_acc <= w_acc_next;
                end
            end

            if (w_load_out) begin
                r_left  <= f_narrow(r_res_l);
                r_right <= f_narrow(r_res_r);
                r_valid <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.LEFT    = r_left;
    assign bus.RIGHT   = r_right;
    assign bus.valid   = r_valid;
    assign bus.busy    = w_busy;
    assign bus.overrun = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_stereo_matrix_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stereo_matrix_decoder
//  Description : Scoreboard bench for stereo_matrix_decoder. The driver
//                pushes the expected LEFT/RIGHT pair and capture edge for
//                each accepted strobe; a monitor pops and compares whenever
//                valid is seen, including the 9-cycle latency.
//                Honours STEREO_DEC_SAT_EN for overflow expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_stereo_matrix_decoder;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    stereo_matrix_decoder_if bus();

    stereo_matrix_decoder dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic signed [17:0] left;
        logic signed [17:0] right;
        int                 e0;
    } exp_t;

    typedef struct {
        logic signed [17:0] lpr;
        logic signed [17:0] lmr;
        logic        [3:0]  kg;
        logic signed [17:0] left;
        logic signed [17:0] right;
    } vec_t;

`ifdef STEREO_DEC_SAT_EN
    localparam logic signed [17:0] c_OVF_LEFT = 18'sd131071;
`else
    localparam logic signed [17:0] c_OVF_LEFT = -18'sd32772;
`endif

    exp_t sb[$];
    exp_t m_exp;
    int   total     = 0;
    int   bad       = 0;
    int   edge_cnt  = 0;
    int   valid_cnt = 0;

    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic signed [31:0] actual,
                         input logic signed [31:0] required);
        total++;
        if (actual !== required) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, actual, required, $time);
        end
    endtask

    // Reference arithmetic for the random section.
    function automatic logic signed [17:0] model(input int lpr, input int lmr,
                                                  input int kg, input bit is_left);
        longint v;
        v = is_left ? longint'(lpr) + longint'(lmr) : longint'(lpr) - longint'(lmr);
        v = (v * kg) >>> 3;
`ifdef STEREO_DEC_SAT_EN
        if (v > 131071) v = 131071;
        else if (v < -131072) v = -131072;
`endif
        return 18'(v);
    endfunction

    // Monitor: compare every valid pulse against the scoreboard head.
    always @(negedge clock) begin
        if (bus.valid === 1'b1) begin
            valid_cnt++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got valid=1 with empty scoreboard, required none (t=%0t)", $time);
            end else begin
                m_exp = sb.pop_front();
                check("left", bus.LEFT, m_exp.left);
                check("right", bus.RIGHT, m_exp.right);
                check("latency", edge_cnt - m_exp.e0, 9);
                check("busy_at_valid", {31'd0, bus.busy}, 0);
            end
        end
    end

    // Drive one strobe; the capture edge is the posedge after the set-up.
    task automatic strobe(input logic signed [17:0] lpr, input logic signed [17:0] lmr,
                          input logic [3:0] kg, input bit expect_it,
                          input logic signed [17:0] el, input logic signed [17:0] er);
        exp_t e;
        @(negedge clock);
        bus.LpR      = lpr;
        bus.LmR      = lmr;
        bus.Kg       = kg;
        bus.clken_48 = 1'b1;
        @(posedge clock);
        #1;
        bus.clken_48 = 1'b0;
        // Disturb live inputs; the decoder must use the captured copies.
        bus.LpR      = ~lpr;
        bus.LmR      = lmr ^ 18'sh15555;
        bus.Kg       = ~kg;
        if (expect_it) begin
            e.left  = el;
            e.right = er;
            e.e0    = edge_cnt;
            sb.push_back(e);
        end
    endtask

    vec_t dir[6];
    int   vc;
    logic signed [17:0] rl, rm;
    logic        [3:0]  rk;

    initial begin
        dir[0] = '{18'sd1000,   18'sd200,    4'd8,  18'sd1200,  18'sd800};
        dir[1] = '{-18'sd1000,  -18'sd500,   4'd8,  -18'sd1500, -18'sd500};
        dir[2] = '{-18'sd100,   18'sd0,      4'd3,  -18'sd38,   -18'sd38};
        dir[3] = '{18'sd100,    18'sd0,      4'd3,  18'sd37,    18'sd37};
        dir[4] = '{18'sd5000,   -18'sd3000,  4'd0,  18'sd0,     18'sd0};
        dir[5] = '{18'sd131071, 18'sd131071, 4'd15, c_OVF_LEFT, 18'sd0};

        bus.clken_48 = 1'b0;
        bus.LpR      = '0;
        bus.LmR      = '0;
        bus.Kg       = '0;

        // Reset, with a strobe held on the same edges: reset must win.
        repeat (2) @(posedge clock);
        @(negedge clock);
        bus.clken_48 = 1'b1;
        bus.Kg       = 4'd8;
        bus.LpR      = 18'sd77;
        @(posedge clock);
        #1;
        bus.clken_48 = 1'b0;
        check("rst_left", bus.LEFT, 0);
        check("rst_right", bus.RIGHT, 0);
        check("rst_valid", {31'd0, bus.valid}, 0);
        check("rst_busy", {31'd0, bus.busy}, 0);
        check("rst_overrun", {31'd0, bus.overrun}, 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(posedge clock);

        // Directed vectors, well spaced.
        foreach (dir[i]) begin
            strobe(dir[i].lpr, dir[i].lmr, dir[i].kg, 1'b1, dir[i].left, dir[i].right);
            repeat (12) @(posedge clock);
        end
        check("overrun_clear_after_directed", {31'd0, bus.overrun}, 0);

        // Overrun: second strobe at E4 is ignored.
        vc = valid_cnt;
        strobe(18'sd10, 18'sd2, 4'd8, 1'b1, 18'sd12, 18'sd8);
        repeat (3) @(posedge clock);
        strobe(18'sd500, -18'sd300, 4'd5, 1'b0, 18'sd0, 18'sd0);
        check("overrun_set", {31'd0, bus.overrun}, 1);
        repeat (12) @(posedge clock);
        check("overrun_single_valid", valid_cnt - vc, 1);
        check("overrun_sticky", {31'd0, bus.overrun}, 1);
        check("hold_left", bus.LEFT, 12);

        // Reset mid-operation (at E5).
        strobe(18'sd4000, 18'sd1000, 4'd8, 1'b0, 18'sd0, 18'sd0);
        repeat (4) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("midrst_left", bus.LEFT, 0);
        check("midrst_right", bus.RIGHT, 0);
        check("midrst_valid", {31'd0, bus.valid}, 0);
        check("midrst_overrun", {31'd0, bus.overrun}, 0);
        check("midrst_busy", {31'd0, bus.busy}, 0);
        @(negedge clock);
        reset = 1'b0;
        vc = valid_cnt;
        repeat (15) @(posedge clock);
        check("midrst_no_valid", valid_cnt - vc, 0);
        strobe(18'sd4000, 18'sd1000, 4'd8, 1'b1, 18'sd5000, 18'sd3000);
        repeat (12) @(posedge clock);

        // Back-to-back at the minimum 10-cycle spacing.
        for (int i = 0; i < 100; i++) begin
            rl = 18'($urandom_range(0, 262143));
            rm = 18'($urandom_range(0, 262143));
            rk = 4'($urandom_range(0, 15));
            strobe(rl, rm, rk, 1'b1, model(rl, rm, rk, 1'b1), model(rl, rm, rk, 1'b0));
            if (i != 99) repeat (9) @(posedge clock);
        end
        for (int k = 0; k < 40 && sb.size() != 0; k++) @(posedge clock);
        repeat (2) @(posedge clock);
        check("b2b_overrun", {31'd0, bus.overrun}, 0);
        check("scoreboard_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
